fir_filter: RTL and testbench

- 4-tap FIR filter for a sample-processing subsystem.
- Coefficients are loaded serially, one per load request; samples arrive one per data-ready request.
- Each accepted sample is shifted into a 4-deep history, multiplied by the Q1.15 coefficients, summed, and presented on fir_out.
- Flags: overflow (err), busy (modwait), and a pulse every 1000 processed samples (one_k_samples).

---
 rtl/fir_pkg.sv | 12 +
 rtl/fir_sample_counter.sv | 16 +
 rtl/fir_filter.sv | 100 ++++++++++
 tb/tb_fir_filter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared sizes and FSM state type for the 4-tap FIR filter
package fir_pkg;
  localparam int NUM_TAPS = 4;
  localparam int DATA_W = 16;
  localparam int SAMPLE_BLOCK = 1000;
  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam int PROD_W = DATA_W + 1;
  localparam int ACC_W = PROD_W + IDX_W;
  localparam int CNT_W = $clog2(SAMPLE_BLOCK);
  // MAC states sit at 4..7 so their low two bits select the tap
  typedef enum logic [2:0] {IDLE, LOAD, STORE, OUT, MAC0, MAC1, MAC2, MAC3} state_t;
endpackage

// File: rtl/fir_sample_counter.sv
// fir_sample_counter: counts written results, wraps at SAMPLE_BLOCK and pulses on the wrapping result
module fir_sample_counter
  import fir_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  logic [CNT_W-1:0] count;
  assign tick = en && count == CNT_W'(SAMPLE_BLOCK - 1);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (en) count <= tick ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/fir_filter.sv
// fir_filter: 4-tap Q1.15 FIR with serial coefficient load and one-tap-per-cycle MAC.
// Define FIR_SATURATE_EN to clamp overflowing results to 0xFFFF instead of wrapping.
module fir_filter
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] fir_coefficient,
  input  logic              load_coeff,
  input  logic              data_ready,
  output logic              one_k_samples,
  output logic              modwait,
  output logic [DATA_W-1:0] fir_out,
  output logic              err
);
  state_t state, next_state;
  logic load_q, ready_q, fin, load_rise, ready_rise, write, ovf;
  logic [IDX_W-1:0] idx, tap;
  logic [DATA_W-1:0] sample_q, result;
  logic [NUM_TAPS-1:0][DATA_W-1:0] coef, hist;
  logic [2*DATA_W-1:0] full_prod;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0] acc;
  assign load_rise = load_coeff & ~load_q;
  assign ready_rise = data_ready & ~ready_q;
  assign modwait = state != IDLE;
  assign write = state == OUT && fin;
  assign tap = state[IDX_W-1:0];
  assign full_prod = (2*DATA_W)'(hist[tap]) * (2*DATA_W)'(coef[tap]);
  assign ovf = |acc[ACC_W-1:DATA_W];
`ifdef FIR_SATURATE_EN
  assign result = ovf ? '1 : acc[DATA_W-1:0];
`else
  assign result = acc[DATA_W-1:0];
`endif
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = load_rise ? LOAD : ready_rise ? STORE : IDLE;
      LOAD:    next_state = IDLE;
      STORE:   next_state = MAC0;
      MAC0:    next_state = MAC1;
      MAC1:    next_state = MAC2;
      MAC2:    next_state = MAC3;
      MAC3:    next_state = OUT;
      OUT:     next_state = fin ? IDLE : OUT;
      default: next_state = IDLE;
    endcase
  end
  // Products are registered, so each MAC cycle adds the previous tap; OUT spends one cycle adding the last tap and one writing
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state <= IDLE;
      load_q <= 1'b0;
      ready_q <= 1'b0;
      fin <= 1'b0;
      idx <= '0;
      sample_q <= '0;
      coef <= '0;
      hist <= '0;
      prod <= '0;
      acc <= '0;
      fir_out <= '0;
      err <= 1'b0;
    end else begin
      state <= next_state;
      load_q <= load_coeff;
      ready_q <= data_ready;
      if (state == IDLE && load_rise) begin
        coef[idx] <= fir_coefficient;
        idx <= idx + 1'b1;
      end
      if (state == IDLE && !load_rise && ready_rise) sample_q <= sample_data;
      if (state == STORE) begin
        hist <= {hist[NUM_TAPS-2:0], sample_q};
        prod <= '0;
        acc <= '0;
      end
      if (state inside {MAC0, MAC1, MAC2, MAC3}) begin
        prod <= PROD_W'(full_prod >> (DATA_W - 1));
        acc <= acc + ACC_W'(prod);
      end
      if (state == OUT) begin
        fin <= ~fin;
        if (!fin) acc <= acc + ACC_W'(prod);
      end
      if (write) begin
        fir_out <= result;
        err <= ovf;
      end
    end
  end
  fir_sample_counter u_count (
    .clk (clk),
    .rst (n_rst),
    .en  (write),
    .tick(one_k_samples)
  );
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed and randomized checks of fir_filter against an arithmetic reference model
module tb_fir_filter;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic [15:0] sample_data = '0;
  logic [15:0] fir_coefficient = '0;
  logic load_coeff = 1'b0;
  logic data_ready = 1'b0;
  logic one_k_samples, modwait, err;
  logic [15:0] fir_out;

  fir_filter dut (
    .clk(clk), .n_rst(n_rst), .sample_data(sample_data), .fir_coefficient(fir_coefficient),
    .load_coeff(load_coeff), .data_ready(data_ready), .one_k_samples(one_k_samples),
    .modwait(modwait), .fir_out(fir_out), .err(err)
  );

  always #5 clk = ~clk;

`ifdef FIR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  longint m_c[4];
  longint m_s[4];
  int m_idx = 0;
  int n_samples = 0;
  logic [15:0] exp_out = '0;
  logic exp_err = 1'b0;

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_c[i] = 0;
      m_s[i] = 0;
    end
    m_idx = 0;
    n_samples = 0;
    exp_out = '0;
    exp_err = 1'b0;
  endtask

  task automatic model_eval();
    longint acc;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += (m_s[i] * m_c[i]) >> 15;
    exp_err = acc > 65535;
    exp_out = (exp_err && SAT) ? 16'hFFFF : 16'(acc);
  endtask

  // Walks the busy window; requests are released after `hold` cycles
  task automatic run_req(input int hold, output int busy, output int pulses, output int early);
    busy = 0;
    pulses = 0;
    early = 0;
    for (int i = 0; i < 20 && modwait; i++) begin
      busy++;
      pulses += int'(one_k_samples);
      if (fir_out !== exp_out || err !== exp_err) early++;
      if (i == hold - 1) begin
        data_ready = 1'b0;
        load_coeff = 1'b0;
      end
      tk();
    end
  endtask

  task automatic start_sample(input logic [15:0] v);
    data_ready = 1'b1;
    sample_data = v;
    tk();
    for (int i = 3; i > 0; i--) m_s[i] = m_s[i-1];
    m_s[0] = v;
    n_samples++;
  endtask

  task automatic finish_sample(input int hold, input int exp_busy);
    int busy, pulses, early;
    run_req(hold, busy, pulses, early);
    sample_data = 16'($urandom);
    model_eval();
    check("sample_busy", busy, exp_busy);
    check("hold_between", early, 0);
    check("one_k", pulses, (n_samples % 1000 == 0) ? 1 : 0);
    check("fir_out", fir_out, exp_out);
    check("err", err, exp_err);
  endtask

  task automatic sample(input logic [15:0] v, input int hold);
    start_sample(v);
    finish_sample(hold, 7);
    data_ready = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    int busy, pulses, early;
    load_coeff = 1'b1;
    fir_coefficient = v;
    tk();
    m_c[m_idx] = v;
    m_idx = (m_idx + 1) % 4;
    run_req(1, busy, pulses, early);
    fir_coefficient = 16'($urandom);
    check("load_busy", busy, 1);
    check("load_hold", early, 0);
    repeat (3) tk();
  endtask

  initial begin
    int busy, pulses, early, idle_pulses;
    int seq[4];
    seq = '{10, 29, 48, 53};
    model_reset();
    repeat (2) tk();
    n_rst = 1'b0;
    idle_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      idle_pulses += int'(one_k_samples) + int'(modwait);
      tk();
    end
    check("rst_fir_out", fir_out, 0);
    check("rst_err", err, 0);
    check("rst_modwait", modwait, 0);
    check("rst_idle_activity", idle_pulses, 0);

    load(16'h8000);
    load(16'hFFFF);
    load(16'hFFFF);
    load(16'h4000);

    for (int k = 0; k < 4; k++) begin
      sample(16'd10, 2);
      check("tap_seq", fir_out, seq[k]);
      repeat (12) tk();
    end
    while (n_samples < 1000) sample(16'd10, 1);

    sample(16'hFFFF, 1);
    check("ovf_out", fir_out, SAT ? 16'hFFFF : 16'h002A);
    check("ovf_err", err, 1);
    repeat (3) sample(16'hFFFF, 1);

    start_sample(16'($urandom));
    data_ready = 1'b0;
    tk();
    tk();
    data_ready = 1'b1;
    load_coeff = 1'b1;
    fir_coefficient = 16'($urandom);
    finish_sample(20, 5);
    tk();
    check("busy_req_ignored", modwait, 0);
    data_ready = 1'b0;
    load_coeff = 1'b0;
    tk();

    start_sample(16'($urandom));
    finish_sample(20, 7);
    tk();
    check("level_once", modwait, 0);
    data_ready = 1'b0;
    tk();

    data_ready = 1'b1;
    load_coeff = 1'b1;
    fir_coefficient = 16'($urandom);
    sample_data = 16'($urandom);
    tk();
    m_c[m_idx] = fir_coefficient;
    m_idx = (m_idx + 1) % 4;
    run_req(1, busy, pulses, early);
    check("both_busy", busy, 1);
    tk();
    check("both_no_sample", modwait, 0);
    check("both_out", fir_out, exp_out);

    repeat (4) load(16'($urandom));
    while (n_samples < 2000) begin
      if (n_samples % 97 == 0) load(16'($urandom));
      sample(16'($urandom), 1);
    end

    start_sample(16'($urandom_range(1, 65535)));
    data_ready = 1'b0;
    tk();
    tk();
    n_rst = 1'b1;
    tk();
    check("mid_rst_fir_out", fir_out, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_modwait", modwait, 0);
    check("mid_rst_one_k", one_k_samples, 0);
    n_rst = 1'b0;
    model_reset();
    tk();
    load(16'h8000);
    sample(16'd1234, 1);
    check("post_rst_out", fir_out, 1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
